// File: rtl/axis_to_scalar_mc_if.sv
// Bundle of the AXI-Stream input and the AXI4-Lite slave channel used by
// axis_to_scalar_mc. The slave modport is the design side, master the driver.
interface axis_to_scalar_mc_if #(
    parameter int TDATA_W = 16,
    parameter int TDEST_W = 3,
    parameter int ADDR_W  = 6
);
    logic [TDATA_W-1:0] s_axis_tdata;
    logic [TDEST_W-1:0] s_axis_tdest;
    logic               s_axis_tvalid;
    logic               s_axis_tready;

    logic [ADDR_W-1:0]  s00_axi_awaddr;
    logic               s00_axi_awvalid;
    logic               s00_axi_awready;
    logic [31:0]        s00_axi_wdata;
    logic [3:0]         s00_axi_wstrb;
    logic               s00_axi_wvalid;
    logic               s00_axi_wready;
    logic [1:0]         s00_axi_bresp;
    logic               s00_axi_bvalid;
    logic               s00_axi_bready;
    logic [ADDR_W-1:0]  s00_axi_araddr;
    logic               s00_axi_arvalid;
    logic               s00_axi_arready;
    logic [31:0]        s00_axi_rdata;
    logic [1:0]         s00_axi_rresp;
    logic               s00_axi_rvalid;
    logic               s00_axi_rready;

    modport slave (
        input  s_axis_tdata, s_axis_tdest, s_axis_tvalid,
        output s_axis_tready,
        input  s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arvalid,
        output s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        input  s00_axi_rready
    );

    modport master (
        output s_axis_tdata, s_axis_tdest, s_axis_tvalid,
        input  s_axis_tready,
        output s00_axi_awaddr, s00_axi_awvalid, s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arvalid,
        input  s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        output s00_axi_rready
    );
endinterface

// File: rtl/axis_to_scalar_mc.sv
// AXI-Stream to multi-channel held scalars. Beats are steered by TDEST into
// per-channel registers (latch or decimate mode); a small AXI4-Lite register
// file exposes control, decimation factor, drop counter and channel values.
module axis_to_scalar_mc #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 6,
    parameter int TDATA_W              = 16,
    parameter int NUM_CH               = 4,
    parameter int TDEST_W              = 3
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_areset,
    axis_to_scalar_mc_if.slave        bus,
    output logic [NUM_CH*TDATA_W-1:0] scalar_out,
    output logic [NUM_CH-1:0]         scalar_upd
);
    localparam int AW = C_S00_AXI_ADDR_WIDTH;

    logic [2:0]         ctrl_q;
    logic [15:0]        decim_q;
    logic [15:0]        drop_q;
    logic [15:0]        cnt_q [NUM_CH];
    logic [TDATA_W-1:0] ch_q  [NUM_CH];
    logic               bvalid_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;

    logic               accept, dest_ok, drop_evt, keep_evt;
    logic               wr_en, rd_en, wr_ctrl, wr_decim, wr_drop;
    logic [AW-3:0]      wr_word, rd_word;
    logic [15:0]        decim_new;
    logic [31:0]        rd_val;
    logic               unused_bits;

    assign accept   = bus.s_axis_tvalid & bus.s_axis_tready;
    assign dest_ok  = int'(bus.s_axis_tdest) < NUM_CH;
    assign drop_evt = accept & (~dest_ok | ctrl_q[2]);
    assign keep_evt = accept & dest_ok & ~ctrl_q[2];

    // Ready is tied to the registered enable bit so it never depends on tvalid.
    assign bus.s_axis_tready = ctrl_q[0];

    assign wr_en    = bus.s00_axi_awvalid & bus.s00_axi_wvalid & ~bvalid_q;
    assign rd_en    = bus.s00_axi_arvalid & ~rvalid_q;
    assign wr_word  = bus.s00_axi_awaddr[AW-1:2];
    assign rd_word  = bus.s00_axi_araddr[AW-1:2];
    assign wr_ctrl  = wr_en & (int'(wr_word) == 0);
    assign wr_decim = wr_en & (int'(wr_word) == 1);
    assign wr_drop  = wr_en & (int'(wr_word) == 2);

    assign bus.s00_axi_awready = wr_en;
    assign bus.s00_axi_wready  = wr_en;
    assign bus.s00_axi_bvalid  = bvalid_q;
    assign bus.s00_axi_bresp   = 2'b00;
    assign bus.s00_axi_arready = rd_en;
    assign bus.s00_axi_rvalid  = rvalid_q;
    assign bus.s00_axi_rresp   = 2'b00;
    assign bus.s00_axi_rdata   = rdata_q;

    assign unused_bits = ^{bus.s00_axi_wdata[31:16], bus.s00_axi_wstrb[3:2],
                           bus.s00_axi_awaddr[1:0], bus.s00_axi_araddr[1:0]};

    // Byte-merge for DECIM; a zero factor is meaningless, so it becomes 1.
    always_comb begin
        decim_new = decim_q;
        if (bus.s00_axi_wstrb[0]) decim_new[7:0]  = bus.s00_axi_wdata[7:0];
        if (bus.s00_axi_wstrb[1]) decim_new[15:8] = bus.s00_axi_wdata[15:8];
        if (decim_new == 16'd0)   decim_new       = 16'd1;
    end

    // Read mux; channel slots beyond NUM_CH and holes in the map return zero.
    always_comb begin
        rd_val = '0;
        case (int'(rd_word))
            0: rd_val[2:0]  = ctrl_q;
            1: rd_val[15:0] = decim_q;
            2: rd_val[15:0] = drop_q;
            default: begin
                for (int k = 0; k < NUM_CH; k++)
                    if (int'(rd_word) == 4 + k) rd_val[TDATA_W-1:0] = ch_q[k];
            end
        endcase
    end

    // Pack channel registers onto the flat scalar bus.
    always_comb begin
        scalar_out = '0;
        for (int k = 0; k < NUM_CH; k++)
            scalar_out[k*TDATA_W +: TDATA_W] = ch_q[k];
    end

    // Register file and AXI4-Lite response channels.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            ctrl_q   <= '0;
            decim_q  <= 16'd1;
            drop_q   <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (wr_ctrl && bus.s00_axi_wstrb[0]) ctrl_q <= bus.s00_axi_wdata[2:0];
            if (wr_decim) decim_q <= decim_new;
            // A clear that coincides with a drop still counts that drop.
            if (wr_drop)
                drop_q <= drop_evt ? 16'd1 : 16'd0;
            else if (drop_evt && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;

            if (wr_en)                    bvalid_q <= 1'b1;
            else if (bus.s00_axi_bready)  bvalid_q <= 1'b0;

            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (bus.s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Channel capture with optional decimation; config writes restart all counters.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            scalar_upd <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                ch_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            scalar_upd <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (keep_evt && int'(bus.s_axis_tdest) == k) begin
                    if (!ctrl_q[1]) begin
                        ch_q[k]       <= bus.s_axis_tdata;
                        scalar_upd[k] <= 1'b1;
                    end else if (cnt_q[k] == decim_q - 16'd1) begin
                        ch_q[k]       <= bus.s_axis_tdata;
                        scalar_upd[k] <= 1'b1;
                        cnt_q[k]      <= '0;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + 16'd1;
                    end
                end
                if (wr_ctrl || wr_decim) cnt_q[k] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axis_to_scalar_mc.sv
// Directed plus randomized bench for axis_to_scalar_mc with a behavioural model.
module tb_axis_to_scalar_mc;
    localparam int NUM_CH = 4;
    localparam int TW     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_CH*TW-1:0] scalar_out;
    logic [NUM_CH-1:0]    scalar_upd;

    always #5 clk = ~clk;

    axis_to_scalar_mc_if #(.TDATA_W(TW), .TDEST_W(3), .ADDR_W(6)) bus ();

    axis_to_scalar_mc #(
        .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(6),
        .TDATA_W(TW), .NUM_CH(NUM_CH), .TDEST_W(3)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst), .bus(bus),
        .scalar_out(scalar_out), .scalar_upd(scalar_upd)
    );

    int vectors = 0;
    int errs    = 0;
    int upd1_cnt = 0;

    // Reference model state
    logic [2:0]  m_ctrl;
    int          m_decim;
    int          m_drop;
    logic [15:0] m_ch [NUM_CH];
    int          m_n  [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_decim = 1; m_drop = 0;
        for (int k = 0; k < NUM_CH; k++) begin m_ch[k] = '0; m_n[k] = 0; end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        int w = int'(a) / 4;
        if (w == 0) return {29'b0, m_ctrl};
        if (w == 1) return 32'(m_decim);
        if (w == 2) return 32'(m_drop);
        if (w >= 4 && w < 4 + NUM_CH) return {16'b0, m_ch[w-4]};
        return 32'd0;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int w = int'(a) / 4;
        logic [15:0] nd;
        if (w == 0 && s[0]) m_ctrl = d[2:0];
        if (w == 1) begin
            nd = 16'(m_decim);
            if (s[0]) nd[7:0]  = d[7:0];
            if (s[1]) nd[15:8] = d[15:8];
            m_decim = (nd == 0) ? 1 : int'(nd);
        end
        if (w == 2) m_drop = 0;
        if (w == 0 || w == 1)
            for (int k = 0; k < NUM_CH; k++) m_n[k] = 0;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        bit done = 0;
        bus.s00_axi_awaddr = a; bus.s00_axi_wdata = d; bus.s00_axi_wstrb = s;
        bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            #1;
            if (bus.s00_axi_awready && bus.s00_axi_wready) done = 1;
            @(posedge clk); #1;
        end
        bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
        chk("aw_handshake", 64'(done), 64'd1);
        if (done) model_write(a, d, s);
        chk("bvalid_bresp", {61'b0, bus.s00_axi_bvalid, bus.s00_axi_bresp}, 64'd4);
        bus.s00_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus.s00_axi_bready = 1'b0;
    endtask

    task automatic axi_read_chk(input string tag, input logic [5:0] a);
        bit done = 0;
        logic [31:0] exp;
        bus.s00_axi_araddr = a; bus.s00_axi_arvalid = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            #1;
            if (bus.s00_axi_arready) begin done = 1; exp = model_read(a); end
            @(posedge clk); #1;
        end
        bus.s00_axi_arvalid = 1'b0;
        chk("ar_handshake", 64'(done), 64'd1);
        chk("rvalid_rresp", {61'b0, bus.s00_axi_rvalid, bus.s00_axi_rresp}, 64'd4);
        if (done) chk(tag, 64'(bus.s00_axi_rdata), 64'(exp));
        bus.s00_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s00_axi_rready = 1'b0;
    endtask

    task automatic step(input bit v, input logic [2:0] dest, input logic [15:0] data);
        logic [NUM_CH-1:0]    exp_upd = '0;
        logic [NUM_CH*TW-1:0] exp_so;
        bus.s_axis_tvalid = v; bus.s_axis_tdest = dest; bus.s_axis_tdata = data;
        @(posedge clk); #1;
        if (v && m_ctrl[0]) begin
            if (int'(dest) >= NUM_CH || m_ctrl[2]) begin
                if (m_drop < 65535) m_drop++;
            end else if (!m_ctrl[1]) begin
                m_ch[dest] = data; exp_upd[dest] = 1'b1;
            end else begin
                m_n[dest]++;
                if (m_n[dest] % m_decim == 0) begin m_ch[dest] = data; exp_upd[dest] = 1'b1; end
            end
        end
        for (int k = 0; k < NUM_CH; k++) exp_so[k*TW +: TW] = m_ch[k];
        if (scalar_upd[1]) upd1_cnt++;
        chk("scalar_upd", 64'(scalar_upd), 64'(exp_upd));
        chk("scalar_out", 64'(scalar_out), 64'(exp_so));
        chk("tready", 64'(bus.s_axis_tready), 64'(m_ctrl[0]));
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 32; a += 4) axi_read_chk(tag, 6'(a));
    endtask

    initial begin
        bus.s_axis_tvalid = 0; bus.s_axis_tdest = 0; bus.s_axis_tdata = 0;
        bus.s00_axi_awaddr = 0; bus.s00_axi_awvalid = 0; bus.s00_axi_wdata = 0;
        bus.s00_axi_wstrb = 0; bus.s00_axi_wvalid = 0; bus.s00_axi_bready = 0;
        bus.s00_axi_araddr = 0; bus.s00_axi_arvalid = 0; bus.s00_axi_rready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        chk("reset_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("reset_upd", 64'(scalar_upd), 64'd0);
        chk("reset_out", 64'(scalar_out), 64'd0);
        read_all("reset_reg");
        axi_read_chk("unmapped_0x3c", 6'h3C);

        // Latch mode, back-to-back beats
        axi_write(6'h00, 32'h1, 4'hF);
        step(1, 3'd0, 16'h1234);
        step(1, 3'd2, 16'hBEEF);
        step(0, 3'd0, 16'h0);
        axi_read_chk("ch0_latch", 6'h10);
        axi_read_chk("ch2_latch", 6'h18);

        // Decimate by 4 on channel 1
        axi_write(6'h00, 32'h3, 4'hF);
        axi_write(6'h04, 32'h4, 4'hF);
        upd1_cnt = 0;
        for (int i = 1; i <= 10; i++) step(1, 3'd1, 16'(i));
        chk("ch1_upd_pulses", 64'(upd1_cnt), 64'd2);
        axi_read_chk("ch1_decim", 6'h14);

        // Freeze drops, out-of-range tdest drops
        axi_write(6'h00, 32'h5, 4'hF);
        for (int i = 0; i < 3; i++) step(1, 3'(i), 16'hA5A0 + 16'(i));
        axi_write(6'h00, 32'h1, 4'hF);
        step(1, 3'd7, 16'hDEAD);
        axi_read_chk("drop_4", 6'h08);
        read_all("after_freeze");

        // Randomized rounds
        for (int r = 0; r < 4; r++) begin
            logic [2:0] c;
            c[0] = (r != 2);
            c[1] = 1'($urandom_range(0, 1));
            c[2] = ($urandom_range(0, 3) == 0);
            axi_write(6'h00, {29'b0, c}, 4'hF);
            axi_write(6'h04, 32'($urandom_range(0, 5)) | (32'($urandom_range(0, 1)) << 8),
                      4'($urandom_range(0, 3)));
            for (int i = 0; i < 150; i++) begin
                logic [2:0] d;
                d = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
                step($urandom_range(0, 3) != 0, d, 16'($urandom));
            end
            read_all("rand_regs");
        end

        // Drop clear coinciding with a dropped beat, then saturation
        axi_write(6'h00, 32'h1, 4'hF);
        bus.s_axis_tvalid = 1; bus.s_axis_tdest = 3'd7; bus.s_axis_tdata = 16'h5555;
        bus.s00_axi_awaddr = 6'h08; bus.s00_axi_wdata = 0; bus.s00_axi_wstrb = 4'hF;
        bus.s00_axi_awvalid = 1; bus.s00_axi_wvalid = 1;
        #1;
        chk("drop_clr_awready", 64'(bus.s00_axi_awready), 64'd1);
        @(posedge clk); #1;
        bus.s_axis_tvalid = 0; bus.s00_axi_awvalid = 0; bus.s00_axi_wvalid = 0;
        m_drop = 1;
        chk("drop_clr_bvalid", 64'(bus.s00_axi_bvalid), 64'd1);
        bus.s00_axi_bready = 1; @(posedge clk); #1; bus.s00_axi_bready = 0;
        axi_read_chk("drop_clr_plus_evt", 6'h08);
        bus.s_axis_tvalid = 1; bus.s_axis_tdest = 3'd7;
        repeat (65536) @(posedge clk);
        #1 bus.s_axis_tvalid = 0;
        m_drop = (m_drop + 65536 > 65535) ? 65535 : m_drop + 65536;
        axi_read_chk("drop_saturate", 6'h08);

        // DECIM zero maps to one; byte strobes
        axi_write(6'h04, 32'h0, 4'hF);
        axi_read_chk("decim_zero", 6'h04);
        axi_write(6'h04, 32'h0000_3377, 4'h2);
        axi_read_chk("decim_strb", 6'h04);

        // Reset while bvalid is pending
        bus.s00_axi_awaddr = 6'h00; bus.s00_axi_wdata = 32'h7; bus.s00_axi_wstrb = 4'hF;
        bus.s00_axi_awvalid = 1; bus.s00_axi_wvalid = 1;
        @(posedge clk); #1;
        bus.s00_axi_awvalid = 0; bus.s00_axi_wvalid = 0;
        chk("pre_rst_bvalid", 64'(bus.s00_axi_bvalid), 64'd1);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_bvalid", 64'(bus.s00_axi_bvalid), 64'd0);
        rst = 0;
        model_reset();
        chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_out", 64'(scalar_out), 64'd0);
        read_all("post_rst_reg");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
